// File: rtl/lap_stopwatch_if.sv
// ---------------------------------------------------------------------------
// lap_stopwatch_if
//   Valid/ready readout channel of the lap-capture FIFO.
//
//   lap_valid : FIFO holds at least one entry (driven by the stopwatch)
//   lap_data  : show-ahead FIFO head (driven by the stopwatch)
//   lap_ready : consumer accepts the head when lap_valid is high
//
//   master : stopwatch side (produces entries)
//   slave  : consumer side (pops entries)
// ---------------------------------------------------------------------------
interface lap_stopwatch_if #(
    parameter int DATA_WIDTH = 16
) ();
    logic                  lap_valid;
    logic [DATA_WIDTH-1:0] lap_data;
    logic                  lap_ready;

    modport master (
        output lap_valid,
        output lap_data,
        input  lap_ready
    );

    modport slave (
        input  lap_valid,
        input  lap_data,
        output lap_ready
    );
endinterface

// File: rtl/lap_stopwatch.sv
// ---------------------------------------------------------------------------
// lap_stopwatch
//   Stopwatch/timer with runtime terminal value, up/down counting, wrap or
//   one-shot halt at the terminal value, a clock prescaler and a lap-capture
//   FIFO read out over a valid/ready channel.
//
//   clk          : clock, all state on rising edge
//   reset        : synchronous, active-high
//   start / stop : begin-resume / pause counting (stop wins over start)
//   clear        : soft clear of count, prescaler, FSM, done and lap FIFO
//   dir          : 0 = up, 1 = down
//   wrap_en      : 1 = wrap at terminal, 0 = halt at terminal
//   max_val      : terminal / reload value, sampled every cycle
//   count        : current count (registered)
//   running      : FSM in RUN (registered)
//   done         : one-cycle pulse after a step that hit the terminal value
//   lap          : push the registered count into the lap FIFO
//   lap_overflow : sticky, a lap was dropped because the FIFO was full
//   lap_if       : FIFO readout (lap_valid / lap_data / lap_ready)
// ---------------------------------------------------------------------------
module lap_stopwatch #(
    parameter int DATA_WIDTH = 16,
    parameter int PRESCALE   = 1,
    parameter int LAPS       = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    input  logic                  dir,
    input  logic                  wrap_en,
    input  logic [DATA_WIDTH-1:0] max_val,
    output logic [DATA_WIDTH-1:0] count,
    output logic                  running,
    output logic                  done,
    input  logic                  lap,
    output logic                  lap_overflow,
    lap_stopwatch_if.master       lap_if
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int PTR_W = (LAPS > 1) ? $clog2(LAPS) : 1;
    localparam int CNT_W = $clog2(LAPS + 1);

    localparam logic [PRE_W-1:0]      PRE_LAST  = PRE_W'(PRESCALE - 1);
    localparam logic [PRE_W-1:0]      PRE_ONE   = PRE_W'(1);
    localparam logic [PTR_W-1:0]      PTR_LAST  = PTR_W'(LAPS - 1);
    localparam logic [PTR_W-1:0]      PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0]      FILL_FULL = CNT_W'(LAPS);
    localparam logic [CNT_W-1:0]      FILL_ONE  = CNT_W'(1);
    localparam logic [DATA_WIDTH-1:0] CNT_ONE   = DATA_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [PRE_W-1:0]      pre_q, pre_d;
    logic [DATA_WIDTH-1:0] count_q, count_d;
    logic                  done_q, done_d;
    logic                  ovf_q, ovf_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      fill_q, fill_d;
    logic [DATA_WIDTH-1:0] mem_q [LAPS];

    logic active, step, terminal, hit_term, halt;
    logic fifo_valid, fifo_full, push_req, push, pop;

    // Next count for one step; terminal handling (wrap or hold) lives here.
    function automatic logic [DATA_WIDTH-1:0] step_value(
        input logic [DATA_WIDTH-1:0] cur,
        input logic [DATA_WIDTH-1:0] lim,
        input logic                  down,
        input logic                  wrap
    );
        if (!down) begin
            // >= rather than == so a max_val lowered below count still terminates
            if (cur >= lim) return wrap ? '0 : cur;
            return cur + CNT_ONE;
        end
        if (cur == '0) return wrap ? lim : cur;
        return cur - CNT_ONE;
    endfunction

    // Circular pointer advance; LAPS need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    // ---- counting datapath: prescaler and count step ----
    always_comb begin
        // The start cycle itself counts as active, so PRESCALE=1 steps on it.
        active   = ((state_q == RUN) || start) && !stop && !clear;
        step     = active && (pre_q == PRE_LAST);
        terminal = dir ? (count_q == '0) : (count_q >= max_val);
        hit_term = step && terminal;
        halt     = hit_term && !wrap_en;
        done_d   = hit_term;

        pre_d = pre_q;
        if (clear)       pre_d = '0;
        else if (active) pre_d = step ? '0 : pre_q + PRE_ONE;

        count_d = count_q;
        if (clear)     count_d = dir ? max_val : '0;
        else if (step) count_d = step_value(count_q, max_val, dir, wrap_en);
    end

    // ---- lap FIFO control ----
    always_comb begin
        fifo_valid = (fill_q != '0);
        fifo_full  = (fill_q == FILL_FULL);
        push_req   = lap && !clear;
        pop        = fifo_valid && lap_if.lap_ready && !clear;
        // A pop in the same cycle frees the slot a full FIFO needs.
        push       = push_req && (!fifo_full || pop);

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        ovf_d    = ovf_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            fill_d   = '0;
            ovf_d    = 1'b0;
        end else begin
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (push && !pop)      fill_d = fill_q + FILL_ONE;
            else if (pop && !push) fill_d = fill_q - FILL_ONE;
            if (push_req && !push) ovf_d = 1'b1;
        end
    end

    // ---- FSM next state ----
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else if (stop) begin
            if (state_q == RUN) state_d = PAUSED;
        end else if (halt) begin
            // A halting step wins even on a start cycle.
            state_d = IDLE;
        end else if (start) begin
            state_d = RUN;
        end
    end

    // ---- state register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            pre_q    <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            count_q  <= count_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
        end
    end

    // Lap storage carries no reset; occupancy is tracked by fill_q.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= count_q;
    end

    // ---- outputs ----
    always_comb begin
        count            = count_q;
        running          = (state_q == RUN);
        done             = done_q;
        lap_overflow     = ovf_q;
        lap_if.lap_valid = fifo_valid;
        lap_if.lap_data  = mem_q[rd_ptr_q];
    end

endmodule

// File: tb/tb_lap_stopwatch.sv
module tb_lap_stopwatch;

    logic        clk = 1'b0;
    logic        reset, start, stop, clear, dir, wrap_en, lap, lap_ready;
    logic [15:0] max_val;

    logic [15:0] count1, count3;
    logic        running1, running3, done1, done3, ovf1, ovf3;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    lap_stopwatch_if #(.DATA_WIDTH(16)) lif1 ();
    lap_stopwatch_if #(.DATA_WIDTH(16)) lif3 ();

    assign lif1.lap_ready = lap_ready;
    assign lif3.lap_ready = lap_ready;

    lap_stopwatch #(.DATA_WIDTH(16), .PRESCALE(1), .LAPS(4)) dut1 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
        .dir(dir), .wrap_en(wrap_en), .max_val(max_val), .count(count1),
        .running(running1), .done(done1), .lap(lap), .lap_overflow(ovf1),
        .lap_if(lif1)
    );

    lap_stopwatch #(.DATA_WIDTH(16), .PRESCALE(3), .LAPS(4)) dut3 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
        .dir(dir), .wrap_en(wrap_en), .max_val(max_val), .count(count3),
        .running(running3), .done(done3), .lap(lap), .lap_overflow(ovf3),
        .lap_if(lif3)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        tot_cnt++; if (count1 !== 16'd0) $display("FAIL rst_count1 got %0d want 0", count1); else pass_cnt++;
        tot_cnt++; if (count3 !== 16'd0) $display("FAIL rst_count3 got %0d want 0", count3); else pass_cnt++;
        tot_cnt++; if (running1 !== 1'b0) $display("FAIL rst_running got %b want 0", running1); else pass_cnt++;
        tot_cnt++; if (done1 !== 1'b0) $display("FAIL rst_done got %b want 0", done1); else pass_cnt++;
        tot_cnt++; if (lif1.lap_valid !== 1'b0) $display("FAIL rst_lap_valid got %b want 0", lif1.lap_valid); else pass_cnt++;
        tot_cnt++; if (ovf1 !== 1'b0) $display("FAIL rst_overflow got %b want 0", ovf1); else pass_cnt++;
    endtask

    task automatic test_wrap_up();
        logic [15:0] exp_c [9] = '{16'd1, 16'd2, 16'd3, 16'd0, 16'd1, 16'd2, 16'd3, 16'd0, 16'd1};
        dir = 1'b0; wrap_en = 1'b1; max_val = 16'd3;
        start = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick(); start = 1'b0;
            tot_cnt++; if (count1 !== exp_c[i]) $display("FAIL wrap_count[%0d] got %0d want %0d", i, count1, exp_c[i]); else pass_cnt++;
            tot_cnt++; if (done1 !== (exp_c[i] == 16'd0)) $display("FAIL wrap_done[%0d] got %b want %b", i, done1, exp_c[i] == 16'd0); else pass_cnt++;
            tot_cnt++; if (running1 !== 1'b1) $display("FAIL wrap_running[%0d] got %b want 1", i, running1); else pass_cnt++;
        end
        stop = 1'b1; tick(); stop = 1'b0;
        tot_cnt++; if (count1 !== 16'd1) $display("FAIL wrap_stop_count got %0d want 1", count1); else pass_cnt++;
        tot_cnt++; if (running1 !== 1'b0) $display("FAIL wrap_stop_running got %b want 0", running1); else pass_cnt++;
    endtask

    task automatic test_prescale_down();
        logic [15:0] e;
        dir = 1'b1; wrap_en = 1'b0; max_val = 16'd5;
        do_clear();
        tot_cnt++; if (count3 !== 16'd5) $display("FAIL ps_clear_count got %0d want 5", count3); else pass_cnt++;
        tot_cnt++; if (running3 !== 1'b0) $display("FAIL ps_clear_running got %b want 0", running3); else pass_cnt++;
        start = 1'b1;
        for (int t = 1; t <= 21; t++) begin
            tick(); start = 1'b0;
            e = (t / 3 >= 5) ? 16'd0 : 16'(5 - t / 3);
            tot_cnt++; if (count3 !== e) $display("FAIL ps_count[%0d] got %0d want %0d", t, count3, e); else pass_cnt++;
            tot_cnt++; if (done3 !== (t == 18)) $display("FAIL ps_done[%0d] got %b want %b", t, done3, t == 18); else pass_cnt++;
            tot_cnt++; if (running3 !== (t < 18)) $display("FAIL ps_running[%0d] got %b want %b", t, running3, t < 18); else pass_cnt++;
        end
    endtask

    task automatic test_pause();
        dir = 1'b0; wrap_en = 1'b1; max_val = 16'd100;
        do_clear();
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick();
        tot_cnt++; if (count1 !== 16'd4) $display("FAIL pause_run_count got %0d want 4", count1); else pass_cnt++;
        stop = 1'b1; tick(); stop = 1'b0;
        tot_cnt++; if (count1 !== 16'd4) $display("FAIL pause_stop_count got %0d want 4", count1); else pass_cnt++;
        tot_cnt++; if (running1 !== 1'b0) $display("FAIL pause_running got %b want 0", running1); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            tick();
            tot_cnt++; if (count1 !== 16'd4) $display("FAIL pause_hold[%0d] got %0d want 4", i, count1); else pass_cnt++;
        end
        start = 1'b1; tick(); start = 1'b0;
        tot_cnt++; if (count1 !== 16'd5) $display("FAIL pause_resume got %0d want 5", count1); else pass_cnt++;
        tot_cnt++; if (running1 !== 1'b1) $display("FAIL pause_resume_running got %b want 1", running1); else pass_cnt++;
        // prescaler kept its phase across the pause (1 of 3 elapsed)
        tot_cnt++; if (count3 !== 16'd1) $display("FAIL ps_hold_a got %0d want 1", count3); else pass_cnt++;
        tick();
        tot_cnt++; if (count3 !== 16'd2) $display("FAIL ps_hold_b got %0d want 2", count3); else pass_cnt++;
        tot_cnt++; if (count1 !== 16'd6) $display("FAIL pause_run2 got %0d want 6", count1); else pass_cnt++;
        stop = 1'b1; start = 1'b1; tick(); stop = 1'b0; start = 1'b0;
        tot_cnt++; if (count1 !== 16'd6) $display("FAIL stopstart_count got %0d want 6", count1); else pass_cnt++;
        tot_cnt++; if (running1 !== 1'b0) $display("FAIL stopstart_running got %b want 0", running1); else pass_cnt++;
        tick();
        tot_cnt++; if (count1 !== 16'd6) $display("FAIL stopstart_hold got %0d want 6", count1); else pass_cnt++;
    endtask

    task automatic test_lap_overflow();
        logic [15:0] tg [5] = '{16'd2, 16'd5, 16'd7, 16'd9, 16'd11};
        int k = 0;
        dir = 1'b0; wrap_en = 1'b1; max_val = 16'd100; lap_ready = 1'b0;
        do_clear();
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (c == 11) begin
                tot_cnt++; if (ovf1 !== 1'b0) $display("FAIL lap_ovf_early got %b want 0", ovf1); else pass_cnt++;
            end
            lap = (k < 5) && (tg[k] == 16'(c));
            if (lap) k++;
            tick();
        end
        lap = 1'b0;
        tot_cnt++; if (ovf1 !== 1'b1) $display("FAIL lap_ovf got %b want 1", ovf1); else pass_cnt++;
        tot_cnt++; if (lif1.lap_valid !== 1'b1) $display("FAIL lap_valid got %b want 1", lif1.lap_valid); else pass_cnt++;
        stop = 1'b1; tick(); stop = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tot_cnt++; if (lif1.lap_data !== tg[i]) $display("FAIL lap_pop[%0d] got %0d want %0d", i, lif1.lap_data, tg[i]); else pass_cnt++;
            lap_ready = 1'b1; tick(); lap_ready = 1'b0;
        end
        tot_cnt++; if (lif1.lap_valid !== 1'b0) $display("FAIL lap_empty got %b want 0", lif1.lap_valid); else pass_cnt++;
        tot_cnt++; if (ovf1 !== 1'b1) $display("FAIL lap_ovf_sticky got %b want 1", ovf1); else pass_cnt++;
    endtask

    task automatic test_full_push_pop();
        logic [15:0] tg [5] = '{16'd2, 16'd5, 16'd7, 16'd9, 16'd12};
        logic [15:0] dr [4] = '{16'd5, 16'd7, 16'd9, 16'd12};
        int k = 0;
        dir = 1'b0; wrap_en = 1'b1; max_val = 16'd100; lap_ready = 1'b0;
        do_clear();
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            lap = (k < 5) && (tg[k] == 16'(c));
            if (lap) k++;
            lap_ready = (c == 12);
            tick();
        end
        lap = 1'b0; lap_ready = 1'b0;
        tot_cnt++; if (ovf1 !== 1'b0) $display("FAIL full_pp_ovf got %b want 0", ovf1); else pass_cnt++;
        stop = 1'b1; tick(); stop = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tot_cnt++; if (lif1.lap_valid !== 1'b1) $display("FAIL full_pp_valid[%0d] got %b want 1", i, lif1.lap_valid); else pass_cnt++;
            tot_cnt++; if (lif1.lap_data !== dr[i]) $display("FAIL full_pp_pop[%0d] got %0d want %0d", i, lif1.lap_data, dr[i]); else pass_cnt++;
            lap_ready = 1'b1; tick(); lap_ready = 1'b0;
        end
        tot_cnt++; if (lif1.lap_valid !== 1'b0) $display("FAIL full_pp_empty got %b want 0", lif1.lap_valid); else pass_cnt++;
        // push with lap_ready into an empty FIFO: entry appears, nothing popped
        lap = 1'b1; lap_ready = 1'b1; tick(); lap = 1'b0; lap_ready = 1'b0;
        tot_cnt++; if (lif1.lap_valid !== 1'b1) $display("FAIL empty_pp_valid got %b want 1", lif1.lap_valid); else pass_cnt++;
        tot_cnt++; if (lif1.lap_data !== 16'd13) $display("FAIL empty_pp_data got %0d want 13", lif1.lap_data); else pass_cnt++;
        lap_ready = 1'b1; tick(); lap_ready = 1'b0;
        tot_cnt++; if (lif1.lap_valid !== 1'b0) $display("FAIL empty_pp_drain got %b want 0", lif1.lap_valid); else pass_cnt++;
    endtask

    task automatic test_reset_midrun();
        dir = 1'b0; wrap_en = 1'b1; max_val = 16'd100; lap_ready = 1'b0;
        do_clear();
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            lap = (c >= 2);
            tick();
        end
        lap = 1'b0;
        tot_cnt++; if (ovf1 !== 1'b1) $display("FAIL mid_pre_ovf got %b want 1", ovf1); else pass_cnt++;
        tot_cnt++; if (count1 !== 16'd7) $display("FAIL mid_pre_count got %0d want 7", count1); else pass_cnt++;
        reset = 1'b1; tick(); reset = 1'b0;
        tot_cnt++; if (count1 !== 16'd0) $display("FAIL mid_rst_count got %0d want 0", count1); else pass_cnt++;
        tot_cnt++; if (running1 !== 1'b0) $display("FAIL mid_rst_running got %b want 0", running1); else pass_cnt++;
        tot_cnt++; if (lif1.lap_valid !== 1'b0) $display("FAIL mid_rst_valid got %b want 0", lif1.lap_valid); else pass_cnt++;
        tot_cnt++; if (ovf1 !== 1'b0) $display("FAIL mid_rst_ovf got %b want 0", ovf1); else pass_cnt++;
        tick();
        tot_cnt++; if (count1 !== 16'd0) $display("FAIL mid_rst_idle got %0d want 0", count1); else pass_cnt++;

        dir = 1'b1; max_val = 16'd9;
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 0; c < 6; c++) begin
            lap = 1'b1; tick();
        end
        lap = 1'b0;
        tot_cnt++; if (ovf1 !== 1'b1) $display("FAIL mid_clr_pre_ovf got %b want 1", ovf1); else pass_cnt++;
        do_clear();
        tot_cnt++; if (count1 !== 16'd9) $display("FAIL mid_clr_count got %0d want 9", count1); else pass_cnt++;
        tot_cnt++; if (running1 !== 1'b0) $display("FAIL mid_clr_running got %b want 0", running1); else pass_cnt++;
        tot_cnt++; if (lif1.lap_valid !== 1'b0) $display("FAIL mid_clr_valid got %b want 0", lif1.lap_valid); else pass_cnt++;
        tot_cnt++; if (ovf1 !== 1'b0) $display("FAIL mid_clr_ovf got %b want 0", ovf1); else pass_cnt++;
        tot_cnt++; if (done1 !== 1'b0) $display("FAIL mid_clr_done got %b want 0", done1); else pass_cnt++;
        tick();
        tot_cnt++; if (count1 !== 16'd9) $display("FAIL mid_clr_idle_count got %0d want 9", count1); else pass_cnt++;
        tot_cnt++; if (running1 !== 1'b0) $display("FAIL mid_clr_idle_running got %b want 0", running1); else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
        dir = 1'b0; wrap_en = 1'b0; lap = 1'b0; lap_ready = 1'b0;
        max_val = 16'd0;
        test_reset();
        test_wrap_up();
        test_prescale_down();
        test_pause();
        test_lap_overflow();
        test_full_push_pop();
        test_reset_midrun();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
